mux_n_1_rr: RTL and testbench

MUX_N_1_RR -- requirements
Module: mux_n_1_rr

---
 rtl/mux_pkg.sv | 15 +
 rtl/rr_pick.sv | 30 +++
 rtl/mux_n_1_rr.sv | 100 ++++++++++
 tb/tb_mux_n_1_rr.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared types and defaults for the N:1 round-robin output-register mux.
package mux_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_RR     = 1'b1;

  localparam int DEFAULT_WIDTH = 3;
  localparam int DEFAULT_N     = 8;

endpackage

// File: rtl/rr_pick.sv
// Rotating priority finder: first set request at or above ptr, wrapping N-1 -> 0.
module rr_pick #(
  parameter int N  = 8,
  parameter int SW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [SW-1:0] idx,
  output logic          any
);

  always_comb begin
    int k;
    k   = 0;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int i = 0; i < N; i++) begin
      k = int'(ptr) + i;
      if (k >= N) k = k - N;
      if (!any && req[k]) begin
        any    = 1'b1;
        gnt[k] = 1'b1;
        idx    = SW'(k);
      end
    end
  end

endmodule

// File: rtl/mux_n_1_rr.sv
// N:1 mux into a single-entry output register, manual or round-robin select.
// Optional transfer counter port xfer_cnt when MUX_N_1_RR_CNT_EN is defined.
//
// state | meaning
// EMPTY | output register holds no word (out_valid=0)
// FULL  | output register holds a word  (out_valid=1)
module mux_n_1_rr
  import mux_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  parameter  int N     = DEFAULT_N,
  localparam int SW    = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mode,
  input  logic [SW-1:0]      s,
  input  logic [N-1:0]       in_valid,
  input  logic [N*WIDTH-1:0] in_data,
  output logic [N-1:0]       in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [SW-1:0]      out_sel,
  input  logic               out_ready
`ifdef MUX_N_1_RR_CNT_EN
  ,
  output logic [15:0]        xfer_cnt
`endif
);

  localparam logic [SW-1:0] LAST = SW'(N - 1);

  state_t        state, state_nxt;
  logic [SW-1:0] ptr;
  logic [N-1:0]  rr_gnt;
  logic [SW-1:0] rr_idx;
  logic          rr_any;
  logic [N-1:0]  sel_gnt;
  logic [SW-1:0] sel_idx;
  logic          can_load;
  logic          load;

  rr_pick #(.N(N), .SW(SW)) u_rr_pick (
    .req (in_valid),
    .ptr (ptr),
    .gnt (rr_gnt),
    .idx (rr_idx),
    .any (rr_any)
  );

  always_comb begin
    sel_gnt = '0;
    sel_idx = s;
    if (mode == MODE_RR) begin
      sel_gnt = rr_gnt;
      sel_idx = rr_idx;
    end else if (int'(s) < N) begin
      sel_gnt[s] = in_valid[s];
    end
  end

  // Load-on-drain: a new word may enter in the same cycle the held one leaves.
  assign can_load  = rst_n && ((state == EMPTY) || out_ready);
  assign in_ready  = can_load ? sel_gnt : '0;
  assign load      = |in_ready;
  assign out_valid = (state == FULL);

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (load) state_nxt = FULL;
      FULL:    if (out_ready && !load) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= EMPTY;
      out_data <= '0;
      out_sel  <= '0;
      ptr      <= '0;
    end else begin
      state <= state_nxt;
      if (load) begin
        out_data <= in_data[int'(sel_idx)*WIDTH +: WIDTH];
        out_sel  <= sel_idx;
        if (mode == MODE_RR) ptr <= (sel_idx == LAST) ? '0 : sel_idx + 1'b1;
      end
    end
  end

`ifdef MUX_N_1_RR_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n)                      xfer_cnt <= '0;
    else if (out_valid && out_ready) xfer_cnt <= xfer_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_mux_n_1_rr.sv
// Scoreboard bench for mux_n_1_rr: a cycle model predicts grants and pushes
// expected words; held/drained words are compared against the queue head.
module tb_mux_n_1_rr;

  localparam int N  = 8;
  localparam int W  = 3;
  localparam int SW = 3;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           mode;
  logic [SW-1:0]  s;
  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_sel;
  logic           out_ready;
`ifdef MUX_N_1_RR_CNT_EN
  logic [15:0]    xfer_cnt;
`endif

  mux_n_1_rr #(.WIDTH(W), .N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .s         (s),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
`ifdef MUX_N_1_RR_CNT_EN
    ,
    .xfer_cnt  (xfer_cnt)
`endif
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  logic             m_full  = 1'b0;
  int               m_ptr   = 0;
  logic [15:0]      m_cnt   = '0;
  logic             was_rst = 1'b0;
  logic [W+SW-1:0]  sb_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Called just after a falling edge with inputs already driven; returns at the next falling edge.
  task automatic tick();
    int              g;
    logic [N-1:0]    exp_rdy;
    logic [W+SW-1:0] head;
    #1;
    g       = -1;
    exp_rdy = '0;
    if (rst_n && (!m_full || out_ready)) begin
      if (mode == 1'b0) begin
        if (in_valid[s]) g = int'(s);
      end else begin
        for (int i = 0; i < N; i++) begin
          int k;
          k = (m_ptr + i) % N;
          if (g < 0 && in_valid[k]) g = k;
        end
      end
    end
    if (g >= 0) exp_rdy[g] = 1'b1;
    check("in_ready", in_ready, exp_rdy);
    check("out_valid", out_valid, m_full);
    if (was_rst) begin
      check("rst_out_data", out_data, 0);
      check("rst_out_sel", out_sel, 0);
    end
    if (m_full && sb_q.size() > 0) begin
      head = sb_q[0];
      check("out_data", out_data, head[W+SW-1:SW]);
      check("out_sel", out_sel, head[SW-1:0]);
    end
`ifdef MUX_N_1_RR_CNT_EN
    check("xfer_cnt", xfer_cnt, m_cnt);
`endif
    if (!rst_n) begin
      m_full  = 1'b0;
      m_ptr   = 0;
      m_cnt   = '0;
      was_rst = 1'b1;
      sb_q.delete();
    end else begin
      was_rst = 1'b0;
      if (m_full && out_ready) begin
        void'(sb_q.pop_front());
        m_cnt = m_cnt + 16'd1;
      end
      if (g >= 0) begin
        sb_q.push_back({in_data[g*W +: W], SW'(g)});
        if (mode) m_ptr = (g + 1) % N;
      end
      m_full = (g >= 0) || (m_full && !out_ready);
    end
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    repeat (n) tick();
    rst_n = 1'b1;
  endtask

  task automatic set_ramp_data();
    for (int k = 0; k < N; k++) in_data[k*W +: W] = W'(k);
  endtask

  initial begin
    rst_n     = 1'b0;
    mode      = 1'b0;
    s         = '0;
    in_valid  = '0;
    out_ready = 1'b1;
    in_data   = '0;
    set_ramp_data();
    @(negedge clk);

    // Reset state, then manual select stepped across all channels
    do_reset(2);
    tick();
    in_valid = '1;
    for (int sv = 0; sv < N; sv++) begin
      s = SW'(sv);
      repeat (10) tick();
      check("man_sel", out_sel, sv);
      check("man_data", out_data, sv);
    end

    // Manual select with nothing valid
    s        = 3'd3;
    in_valid = '0;
    repeat (4) tick();
    check("man_none_valid", out_valid, 0);

    // Round-robin over all-valid requests, wrapping after channel 7
    do_reset(1);
    mode     = 1'b1;
    in_valid = '1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("rr_seq_sel", out_sel, i % N);
    end

    // Sparse requests starting from ptr=3
    do_reset(1);
    in_valid = 8'b0000_0100;
    tick();
    in_valid = 8'b1000_0100;
    #1 check("rr_sparse_1", in_ready, 8'h80);
    tick();
    #1 check("rr_sparse_2", in_ready, 8'h04);
    tick();
    #1 check("rr_sparse_3", in_ready, 8'h80);
    tick();

    // Stall with a held word of 5, then drain and reload in one cycle
    do_reset(1);
    mode      = 1'b0;
    s         = 3'd5;
    in_valid  = '1;
    out_ready = 1'b0;
    tick();
    s = 3'd6;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("stall_data", out_data, 5);
      check("stall_sel", out_sel, 5);
    end
    out_ready = 1'b1;
    #1 check("drain_rdy", in_ready, 8'h40);
    tick();
    check("drain_reload", out_sel, 6);

    // Reset while holding a word; ptr must restart at 0
    out_ready = 1'b0;
    tick();
    do_reset(1);
    tick();
    mode      = 1'b1;
    out_ready = 1'b1;
    tick();
    check("post_rst_rr_first", out_sel, 0);

    // Random traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < N; k++) in_data[k*W +: W] = W'($urandom_range(0, 7));
      mode      = 1'($urandom_range(0, 1));
      s         = SW'($urandom_range(0, N - 1));
      in_valid  = N'($urandom_range(0, 255));
      out_ready = ($urandom_range(0, 3) != 0);
      rst_n     = ($urandom_range(0, 50) != 0);
      tick();
    end
    rst_n = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
